// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes, functs, ALU codes
// and the bundle of per-state control signals.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_TRAP    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BLE   = 6'b011111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SLL = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Raw per-state decode, before the reset/mem_ready/zero qualification applied in the top.
  typedef struct packed {
    logic       iord;
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic       memwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       lessequal;
    logic [2:0] alucontrol;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/mc_aludec.sv
// R-type ALU decoder: maps funct to an ALU operation and flags functs the datapath cannot run.
module mc_aludec (
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       funct_valid
);
  import mc_pkg::*;

  always_comb begin
    alucontrol  = ALU_ADD;
    funct_valid = 1'b1;
    case (funct)
      FN_ADD:  alucontrol = ALU_ADD;
      FN_SUB:  alucontrol = ALU_SUB;
      FN_AND:  alucontrol = ALU_AND;
      FN_OR:   alucontrol = ALU_OR;
      FN_SLT:  alucontrol = ALU_SLT;
      FN_SLL:  alucontrol = ALU_SLL;
      default: funct_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore controller for the shared-memory multicycle MIPS datapath; stalls on mem_ready
// and parks in TRAP on any undecodable instruction until reset.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       irwrite,
  output logic       pcen,
  output logic       memwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       lessequal,
  output logic [2:0] alucontrol,
  output logic       illegal,
  output logic [3:0] state_o
);
  import mc_pkg::*;

  state_t     r_state;
  state_t     w_next_state;
  ctrl_t      w_ctrl;
  logic [2:0] w_rtype_alu;
  logic       w_funct_valid;

  mc_aludec u_aludec (
    .funct       (funct),
    .alucontrol  (w_rtype_alu),
    .funct_valid (w_funct_valid)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_FETCH;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = S_TRAP;
    case (r_state)
      S_FETCH:   w_next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW:   w_next_state = S_MEMADR;
          OP_RTYPE:       w_next_state = w_funct_valid ? S_EXECUTE : S_TRAP;
          OP_BEQ, OP_BLE: w_next_state = S_BRANCH;
          OP_ADDI:        w_next_state = S_ADDIEX;
          OP_J:           w_next_state = S_JUMP;
          default:        w_next_state = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        case (op)
          OP_LW:   w_next_state = S_MEMRD;
          OP_SW:   w_next_state = S_MEMWR;
          default: w_next_state = S_TRAP;
        endcase
      end
      S_MEMRD:   w_next_state = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:   w_next_state = S_FETCH;
      S_MEMWR:   w_next_state = mem_ready ? S_FETCH : S_MEMWR;
      S_EXECUTE: w_next_state = S_ALUWB;
      S_ALUWB:   w_next_state = S_FETCH;
      S_BRANCH:  w_next_state = S_FETCH;
      S_ADDIEX:  w_next_state = S_ADDIWB;
      S_ADDIWB:  w_next_state = S_FETCH;
      S_JUMP:    w_next_state = S_FETCH;
      S_TRAP:    w_next_state = S_TRAP;
      default:   w_next_state = S_TRAP;
    endcase
  end

  always_comb begin
    w_ctrl = '0;
    case (r_state)
      S_FETCH: begin
        w_ctrl.alusrcb    = 2'b01;
        w_ctrl.alucontrol = ALU_ADD;
        w_ctrl.irwrite    = mem_ready;
        w_ctrl.pcwrite    = mem_ready;
      end
      S_DECODE: begin
        w_ctrl.alusrcb    = 2'b11;
        w_ctrl.alucontrol = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        w_ctrl.alusrca    = 1'b1;
        w_ctrl.alusrcb    = 2'b10;
        w_ctrl.alucontrol = ALU_ADD;
      end
      S_MEMRD: w_ctrl.iord = 1'b1;
      S_MEMWB: begin
        w_ctrl.regwrite = 1'b1;
        w_ctrl.memtoreg = 1'b1;
      end
      // Strobe stays up across stalls; memory commits once, on the mem_ready cycle.
      S_MEMWR: begin
        w_ctrl.iord     = 1'b1;
        w_ctrl.memwrite = 1'b1;
      end
      S_EXECUTE: begin
        w_ctrl.alusrca    = 1'b1;
        w_ctrl.alucontrol = w_rtype_alu;
      end
      S_ALUWB: begin
        w_ctrl.regwrite = 1'b1;
        w_ctrl.regdst   = 1'b1;
      end
      S_BRANCH: begin
        w_ctrl.alusrca    = 1'b1;
        w_ctrl.alucontrol = ALU_SUB;
        w_ctrl.pcsrc      = 2'b01;
        w_ctrl.branch     = 1'b1;
        w_ctrl.lessequal  = (op == OP_BLE);
      end
      S_ADDIWB: w_ctrl.regwrite = 1'b1;
      S_JUMP: begin
        w_ctrl.pcsrc   = 2'b10;
        w_ctrl.pcwrite = 1'b1;
      end
      S_TRAP:  w_ctrl.illegal = 1'b1;
      default: w_ctrl = '0;
    endcase
  end

  // Enables are qualified by reset_n so nothing commits while reset is held.
  assign irwrite    = w_ctrl.irwrite & reset_n;
  assign pcen       = (w_ctrl.pcwrite | (w_ctrl.branch & zero)) & reset_n;
  assign memwrite   = w_ctrl.memwrite & reset_n;
  assign regwrite   = w_ctrl.regwrite & reset_n;
  assign iord       = w_ctrl.iord;
  assign regdst     = w_ctrl.regdst;
  assign memtoreg   = w_ctrl.memtoreg;
  assign alusrca    = w_ctrl.alusrca;
  assign alusrcb    = w_ctrl.alusrcb;
  assign pcsrc      = w_ctrl.pcsrc;
  assign lessequal  = w_ctrl.lessequal;
  assign alucontrol = w_ctrl.alucontrol;
  assign illegal    = w_ctrl.illegal;
  assign state_o    = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle vector table plus hand-written reset,
// latency and trap sequences.
module tb_multicycle_ctrl;
  import mc_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       iord, irwrite, pcen, memwrite, regwrite, regdst, memtoreg, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic       lessequal;
  logic [2:0] alucontrol;
  logic       illegal;
  logic [3:0] state_o;

  int checks   = 0;
  int failures = 0;

  multicycle_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .iord       (iord),
    .irwrite    (irwrite),
    .pcen       (pcen),
    .memwrite   (memwrite),
    .regwrite   (regwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .lessequal  (lessequal),
    .alucontrol (alucontrol),
    .illegal    (illegal),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  // {iord, irwrite, pcen, memwrite, regwrite, regdst, memtoreg, alusrca,
  //  alusrcb[1:0], pcsrc[1:0], lessequal, alucontrol[2:0], illegal}
  logic [16:0] act;
  assign act = {iord, irwrite, pcen, memwrite, regwrite, regdst, memtoreg, alusrca,
                alusrcb, pcsrc, lessequal, alucontrol, illegal};

  localparam logic [16:0] E_FETCH_RDY  = {7'b0110000, 1'b0, 2'b01, 2'b00, 1'b0, 3'b010, 1'b0};
  localparam logic [16:0] E_FETCH_WAIT = {7'b0000000, 1'b0, 2'b01, 2'b00, 1'b0, 3'b010, 1'b0};
  localparam logic [16:0] E_DECODE     = {7'b0000000, 1'b0, 2'b11, 2'b00, 1'b0, 3'b010, 1'b0};
  localparam logic [16:0] E_MEMADR     = {7'b0000000, 1'b1, 2'b10, 2'b00, 1'b0, 3'b010, 1'b0};
  localparam logic [16:0] E_MEMRD      = {7'b1000000, 1'b0, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0};
  localparam logic [16:0] E_MEMWB      = {7'b0000101, 1'b0, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0};
  localparam logic [16:0] E_MEMWR      = {7'b1001000, 1'b0, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0};
  localparam logic [16:0] E_ALUWB      = {7'b0000110, 1'b0, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0};
  localparam logic [16:0] E_BR_LE_T    = {7'b0010000, 1'b1, 2'b00, 2'b01, 1'b1, 3'b110, 1'b0};
  localparam logic [16:0] E_BR_EQ_F    = {7'b0000000, 1'b1, 2'b00, 2'b01, 1'b0, 3'b110, 1'b0};
  localparam logic [16:0] E_BR_EQ_T    = {7'b0010000, 1'b1, 2'b00, 2'b01, 1'b0, 3'b110, 1'b0};
  localparam logic [16:0] E_ADDIEX     = {7'b0000000, 1'b1, 2'b10, 2'b00, 1'b0, 3'b010, 1'b0};
  localparam logic [16:0] E_ADDIWB     = {7'b0000100, 1'b0, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0};
  localparam logic [16:0] E_JUMP       = {7'b0010000, 1'b0, 2'b00, 2'b10, 1'b0, 3'b000, 1'b0};
  localparam logic [16:0] E_TRAP       = {7'b0000000, 1'b0, 2'b00, 2'b00, 1'b0, 3'b000, 1'b1};

  function automatic logic [16:0] e_exec(input logic [2:0] alu);
    return {7'b0000000, 1'b1, 2'b00, 2'b00, 1'b0, alu, 1'b0};
  endfunction

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        rdy;
    state_t      st;
    logic [16:0] ctl;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [5:0] o, input logic [5:0] f, input logic z, input logic r,
                     input state_t s, input logic [16:0] c);
    vec_t v;
    v.op = o; v.funct = f; v.zero = z; v.rdy = r; v.st = s; v.ctl = c;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, actual, required);
    end
  endtask

  // Called at posedge+1: drive, sample mid-cycle, then advance to next posedge+1.
  task automatic step(input vec_t v, input int idx);
    op = v.op; funct = v.funct; zero = v.zero; mem_ready = v.rdy;
    #2;
    chk($sformatf("row%0d_state", idx), {28'd0, state_o}, {28'd0, v.st});
    chk($sformatf("row%0d_ctl", idx), {15'd0, act}, {15'd0, v.ctl});
    @(posedge clk); #1;
  endtask

  task automatic run_row(input logic [5:0] o, input logic [5:0] f, input logic z, input logic r,
                         input state_t s, input logic [16:0] c, input string nm);
    vec_t v;
    v.op = o; v.funct = f; v.zero = z; v.rdy = r; v.st = s; v.ctl = c;
    op = v.op; funct = v.funct; zero = v.zero; mem_ready = v.rdy;
    #2;
    chk({nm, "_state"}, {28'd0, state_o}, {28'd0, v.st});
    chk({nm, "_ctl"}, {15'd0, act}, {15'd0, v.ctl});
    @(posedge clk); #1;
  endtask

  task automatic latency(input logic [5:0] o, input logic [5:0] f, input int required,
                         input string nm);
    int n = 0;
    op = o; funct = f; zero = 1'b0; mem_ready = 1'b1;
    do begin
      @(posedge clk); #1;
      n++;
    end while (state_o != S_FETCH && n < 20);
    $display("txn %s cycles=%0d expected=%0d", nm, n, required);
    chk({nm, "_cycles"}, n, required);
  endtask

  task automatic reset_pulse(input string nm);
    reset_n = 1'b0;
    #2;
    chk({nm, "_rst_state"}, {28'd0, state_o}, {28'd0, S_FETCH});
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  logic [5:0] r_functs [6] = '{FN_SLL, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
  logic [2:0] r_alus   [6] = '{3'b011, 3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

  initial begin
    reset_n = 1'b1; op = OP_RTYPE; funct = FN_ADD; zero = 1'b0; mem_ready = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    chk("reset_state", {28'd0, state_o}, {28'd0, S_FETCH});
    chk("reset_ctl", {15'd0, act}, {15'd0, E_FETCH_WAIT});
    @(posedge clk); #1;
    reset_n = 1'b1;

    // LW, zero wait
    add(OP_LW, 6'd0, 0, 1, S_FETCH,  E_FETCH_RDY);
    add(OP_LW, 6'd0, 0, 1, S_DECODE, E_DECODE);
    add(OP_LW, 6'd0, 0, 1, S_MEMADR, E_MEMADR);
    add(OP_LW, 6'd0, 0, 1, S_MEMRD,  E_MEMRD);
    add(OP_LW, 6'd0, 0, 1, S_MEMWB,  E_MEMWB);
    // LW, two MEMRD stalls
    add(OP_LW, 6'd0, 0, 1, S_FETCH,  E_FETCH_RDY);
    add(OP_LW, 6'd0, 0, 1, S_DECODE, E_DECODE);
    add(OP_LW, 6'd0, 0, 1, S_MEMADR, E_MEMADR);
    add(OP_LW, 6'd0, 0, 0, S_MEMRD,  E_MEMRD);
    add(OP_LW, 6'd0, 0, 0, S_MEMRD,  E_MEMRD);
    add(OP_LW, 6'd0, 0, 1, S_MEMRD,  E_MEMRD);
    add(OP_LW, 6'd0, 0, 1, S_MEMWB,  E_MEMWB);
    // SW, three MEMWR stalls: memwrite high for four cycles
    add(OP_SW, 6'd0, 0, 1, S_FETCH,  E_FETCH_RDY);
    add(OP_SW, 6'd0, 0, 1, S_DECODE, E_DECODE);
    add(OP_SW, 6'd0, 0, 1, S_MEMADR, E_MEMADR);
    add(OP_SW, 6'd0, 0, 0, S_MEMWR,  E_MEMWR);
    add(OP_SW, 6'd0, 0, 0, S_MEMWR,  E_MEMWR);
    add(OP_SW, 6'd0, 0, 0, S_MEMWR,  E_MEMWR);
    add(OP_SW, 6'd0, 0, 1, S_MEMWR,  E_MEMWR);
    // SW, two FETCH stalls: irwrite pulses only on the ready cycle
    add(OP_SW, 6'd0, 0, 0, S_FETCH,  E_FETCH_WAIT);
    add(OP_SW, 6'd0, 0, 0, S_FETCH,  E_FETCH_WAIT);
    add(OP_SW, 6'd0, 0, 1, S_FETCH,  E_FETCH_RDY);
    add(OP_SW, 6'd0, 0, 1, S_DECODE, E_DECODE);
    add(OP_SW, 6'd0, 0, 1, S_MEMADR, E_MEMADR);
    add(OP_SW, 6'd0, 0, 1, S_MEMWR,  E_MEMWR);
    // Branches
    add(OP_BLE, 6'd0, 1, 1, S_FETCH,  E_FETCH_RDY);
    add(OP_BLE, 6'd0, 1, 1, S_DECODE, E_DECODE);
    add(OP_BLE, 6'd0, 1, 1, S_BRANCH, E_BR_LE_T);
    add(OP_BEQ, 6'd0, 0, 1, S_FETCH,  E_FETCH_RDY);
    add(OP_BEQ, 6'd0, 0, 1, S_DECODE, E_DECODE);
    add(OP_BEQ, 6'd0, 0, 1, S_BRANCH, E_BR_EQ_F);
    add(OP_BEQ, 6'd0, 1, 1, S_FETCH,  E_FETCH_RDY);
    add(OP_BEQ, 6'd0, 1, 1, S_DECODE, E_DECODE);
    add(OP_BEQ, 6'd0, 1, 1, S_BRANCH, E_BR_EQ_T);
    // Every supported R-type funct
    for (int k = 0; k < 6; k++) begin
      add(OP_RTYPE, r_functs[k], 0, 1, S_FETCH,   E_FETCH_RDY);
      add(OP_RTYPE, r_functs[k], 0, 1, S_DECODE,  E_DECODE);
      add(OP_RTYPE, r_functs[k], 0, 1, S_EXECUTE, e_exec(r_alus[k]));
      add(OP_RTYPE, r_functs[k], 0, 1, S_ALUWB,   E_ALUWB);
    end
    // Back-to-back ADDI, J, ADDI
    add(OP_ADDI, 6'd0, 0, 1, S_FETCH,  E_FETCH_RDY);
    add(OP_ADDI, 6'd0, 0, 1, S_DECODE, E_DECODE);
    add(OP_ADDI, 6'd0, 0, 1, S_ADDIEX, E_ADDIEX);
    add(OP_ADDI, 6'd0, 0, 1, S_ADDIWB, E_ADDIWB);
    add(OP_J,    6'd0, 0, 1, S_FETCH,  E_FETCH_RDY);
    add(OP_J,    6'd0, 0, 1, S_DECODE, E_DECODE);
    add(OP_J,    6'd0, 0, 1, S_JUMP,   E_JUMP);
    add(OP_ADDI, 6'd0, 0, 1, S_FETCH,  E_FETCH_RDY);
    add(OP_ADDI, 6'd0, 0, 1, S_DECODE, E_DECODE);
    add(OP_ADDI, 6'd0, 0, 1, S_ADDIEX, E_ADDIEX);
    add(OP_ADDI, 6'd0, 0, 1, S_ADDIWB, E_ADDIWB);
    add(OP_ADDI, 6'd0, 0, 1, S_FETCH,  E_FETCH_RDY);

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);
    $display("txn vector_table rows=%0d", tbl.size());

    // Zero-wait latencies; the table left the FSM in DECODE, so let it finish ADDI first.
    latency(OP_ADDI, 6'd0, 3, "addi_tail");
    latency(OP_LW,    6'd0,   5, "lw");
    latency(OP_SW,    6'd0,   4, "sw");
    latency(OP_RTYPE, FN_ADD, 4, "add");
    latency(OP_ADDI,  6'd0,   4, "addi");
    latency(OP_BEQ,   6'd0,   3, "beq");
    latency(OP_BLE,   6'd0,   3, "ble");
    latency(OP_J,     6'd0,   3, "j");

    // Reset asserted while a store is stalled in MEMWR
    run_row(OP_SW, 6'd0, 0, 1, S_FETCH,  E_FETCH_RDY, "rst_f");
    run_row(OP_SW, 6'd0, 0, 1, S_DECODE, E_DECODE,    "rst_d");
    run_row(OP_SW, 6'd0, 0, 1, S_MEMADR, E_MEMADR,    "rst_a");
    run_row(OP_SW, 6'd0, 0, 0, S_MEMWR,  E_MEMWR,     "rst_w");
    mem_ready = 1'b1;
    reset_n = 1'b0;
    #2;
    chk("midrst_state", {28'd0, state_o}, {28'd0, S_FETCH});
    chk("midrst_memwrite", {31'd0, memwrite}, 32'd0);
    chk("midrst_ctl", {15'd0, act}, {15'd0, E_FETCH_WAIT});
    @(posedge clk); #1;
    chk("midrst_hold_memwrite", {31'd0, memwrite}, 32'd0);
    chk("midrst_hold_state", {28'd0, state_o}, {28'd0, S_FETCH});
    reset_n = 1'b1;
    #2;
    chk("release_irwrite", {31'd0, irwrite}, 32'd1);
    chk("release_pcen", {31'd0, pcen}, 32'd1);
    @(posedge clk); #1;
    chk("release_next_state", {28'd0, state_o}, {28'd0, S_DECODE});
    $display("txn reset_mid_memwr done");
    repeat (3) begin @(posedge clk); #1; end
    chk("release_sw_done", {28'd0, state_o}, {28'd0, S_FETCH});

    // Illegal funct: TRAP absorbs regardless of mem_ready until reset
    run_row(OP_RTYPE, 6'b100111, 0, 1, S_FETCH,  E_FETCH_RDY, "trapf_f");
    run_row(OP_RTYPE, 6'b100111, 0, 1, S_DECODE, E_DECODE,    "trapf_d");
    for (int i = 0; i < 10; i++) begin
      mem_ready = i[0];
      zero = ~i[0];
      #2;
      chk($sformatf("trap%0d_state", i), {28'd0, state_o}, {28'd0, S_TRAP});
      chk($sformatf("trap%0d_ctl", i), {15'd0, act}, {15'd0, E_TRAP});
      @(posedge clk); #1;
    end
    $display("txn illegal_funct trapped");
    reset_pulse("trapf");

    // Illegal opcode
    run_row(6'b111111, 6'd0, 0, 1, S_FETCH,  E_FETCH_RDY, "trapo_f");
    run_row(6'b111111, 6'd0, 0, 1, S_DECODE, E_DECODE,    "trapo_d");
    run_row(6'b111111, 6'd0, 0, 1, S_TRAP,   E_TRAP,      "trapo_t");
    $display("txn illegal_op trapped");
    reset_pulse("trapo");
    run_row(OP_J, 6'd0, 0, 1, S_FETCH, E_FETCH_RDY, "post_trap_f");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
